reaction_round_ctrl: RTL and testbench

REACTION_ROUND_CTRL -- requirements
Module: reaction_round_ctrl

---
 rtl/reaction_round_ctrl_pkg.sv | 30 +++
 rtl/btn_edge.sv | 21 ++
 rtl/reaction_round_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_reaction_round_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_round_ctrl_pkg.sv
// Shared state encoding, display constants and default tick rates for the reaction-round game.
package reaction_round_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StTarget = 3'd1,
        StCount  = 3'd2,
        StScore  = 3'd3,
        StFinal  = 3'd4
    } state_e;

    localparam logic [13:0] TARGET_LO  = 14'd1000;
    localparam logic [13:0] TARGET_OFS = 14'd7000;
    localparam logic [13:0] NUM_MAX    = 14'd9999;

    localparam int unsigned DEF_TICKS_0 = 1000000;
    localparam int unsigned DEF_TICKS_1 = 200000;
    localparam int unsigned DEF_TICKS_2 = 100000;

    // Folds any 14-bit random value into the four-digit range 1000..9999.
    function automatic logic [13:0] map_target(input logic [13:0] raw);
        if (raw < TARGET_LO) begin
            return raw + TARGET_LO;
        end else if (raw > NUM_MAX) begin
            return raw - TARGET_OFS;
        end
        return raw;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button: one-cycle pulse on a 0->1 transition.
module btn_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/reaction_round_ctrl.sv
// Reaction-timing game: shows a target, counts up until the player stops it, and scores the
// stop error per round and over a whole game on a numeric display and an LED bar.
module reaction_round_ctrl
    import reaction_round_ctrl_pkg::*;
#(
    parameter int unsigned NUM_MODES = 3,
    parameter int unsigned TICKS_0   = DEF_TICKS_0,
    parameter int unsigned TICKS_1   = DEF_TICKS_1,
    parameter int unsigned TICKS_2   = DEF_TICKS_2,
    parameter int unsigned ROUNDS    = 4,
    parameter int unsigned LED_W     = 16,
    parameter int unsigned LED_STEP  = 30,
    parameter int unsigned ERR_CAP   = 490
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_btn_up,
    input  logic             i_btn_down,
    input  logic             i_btn_sel,
    input  logic [13:0]      i_rand,
    output logic [2:0]       o_select,
    output logic [1:0]       o_mode,
    output logic [13:0]      o_number,
    output logic [LED_W-1:0] o_led,
    output logic [3:0]       o_round,
    output logic             o_done
);

    localparam int unsigned TICK_MAX_01 = (TICKS_0 > TICKS_1) ? TICKS_0 : TICKS_1;
    localparam int unsigned TICK_MAX    = (TICK_MAX_01 > TICKS_2) ? TICK_MAX_01 : TICKS_2;
    localparam int unsigned TICK_W      = $clog2(TICK_MAX + 1);

    localparam logic [1:0]  MODE_MAX   = 2'(NUM_MODES - 1);
    localparam logic [3:0]  ROUND_LAST = 4'(ROUNDS);
    localparam logic [13:0] ERR_CAP_W  = 14'(ERR_CAP);
    localparam logic [13:0] ROUNDS_W   = 14'(ROUNDS);
    localparam logic [13:0] STEP_W     = 14'(LED_STEP);
    localparam logic [13:0] LED_CNT_W  = 14'(LED_W);

    state_e              r_state;
    logic [1:0]          r_mode;
    logic [13:0]         r_number;
    logic [13:0]         r_target;
    logic [13:0]         r_total;
    logic [LED_W-1:0]    r_led;
    logic [3:0]          r_round;
    logic                r_done;
    logic [TICK_W-1:0]   r_tick;

    logic                w_up;
    logic                w_down;
    logic                w_sel;
    logic [13:0]         w_target;
    logic [TICK_W-1:0]   w_tick_last;
    logic [13:0]         w_diff;
    logic [13:0]         w_err;
    logic [14:0]         w_sum;
    logic [13:0]         w_total;

    // Divisors are elaboration-time constants, so this folds to fixed logic.
    function automatic logic [LED_W-1:0] led_bar(input logic [13:0] err);
        logic [13:0] k;
        k = err / STEP_W;
        if (k > LED_CNT_W) begin
            k = LED_CNT_W;
        end
        return {LED_W{1'b1}} << k;
    endfunction

    btn_edge u_edge_up (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (i_btn_up),
        .o_rise (w_up)
    );

    btn_edge u_edge_down (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (i_btn_down),
        .o_rise (w_down)
    );

    btn_edge u_edge_sel (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (i_btn_sel),
        .o_rise (w_sel)
    );

    assign w_target = map_target(i_rand);

    always_comb begin
        case (r_mode)
            2'd0:    w_tick_last = TICK_W'(TICKS_0 - 1);
            2'd1:    w_tick_last = TICK_W'(TICKS_1 - 1);
            default: w_tick_last = TICK_W'(TICKS_2 - 1);
        endcase
    end

    always_comb begin
        w_diff  = (r_number >= r_target) ? (r_number - r_target) : (r_target - r_number);
        w_err   = (w_diff > ERR_CAP_W) ? ERR_CAP_W : w_diff;
        w_sum   = {1'b0, r_total} + {1'b0, w_err};
        w_total = (w_sum > {1'b0, NUM_MAX}) ? NUM_MAX : w_sum[13:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_mode   <= 2'd1;
            r_number <= '0;
            r_target <= '0;
            r_total  <= '0;
            r_led    <= '0;
            r_round  <= '0;
            r_done   <= 1'b0;
            r_tick   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_sel) begin
                        r_state  <= StTarget;
                        r_target <= w_target;
                        r_number <= w_target;
                        r_round  <= r_round + 4'd1;
                        r_led    <= '0;
                    end else if (w_up && !w_down && (r_mode < MODE_MAX)) begin
                        r_mode <= r_mode + 2'd1;
                    end else if (w_down && !w_up && (r_mode != 2'd0)) begin
                        r_mode <= r_mode - 2'd1;
                    end
                end
                StTarget: begin
                    if (w_sel) begin
                        r_state  <= StCount;
                        r_number <= '0;
                        r_tick   <= '0;
                    end
                end
                StCount: begin
                    if (w_sel) begin
                        r_state  <= StScore;
                        r_number <= w_err;
                        r_total  <= w_total;
                        r_led    <= led_bar(w_err);
                    end else if (r_tick == w_tick_last) begin
                        r_tick   <= '0;
                        r_number <= (r_number == NUM_MAX) ? '0 : (r_number + 14'd1);
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                StScore: begin
                    if (w_sel) begin
                        if (r_round == ROUND_LAST) begin
                            r_state  <= StFinal;
                            r_number <= r_total;
                            r_led    <= led_bar(r_total / ROUNDS_W);
                            r_done   <= 1'b1;
                        end else begin
                            r_state  <= StTarget;
                            r_target <= w_target;
                            r_number <= w_target;
                            r_round  <= r_round + 4'd1;
                            r_led    <= '0;
                        end
                    end
                end
                StFinal: begin
                    if (w_sel) begin
                        r_state  <= StIdle;
                        r_number <= '0;
                        r_total  <= '0;
                        r_led    <= '0;
                        r_round  <= '0;
                        r_done   <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_select = r_state;
    assign o_mode   = r_mode;
    assign o_number = r_number;
    assign o_led    = r_led;
    assign o_round  = r_round;
    assign o_done   = r_done;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl: a game-level model checked every cycle, plus literal checks.
module tb_reaction_round_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_sel = 1'b0;
    logic [13:0] rand_v = 14'd0;
    logic [2:0]  d_select;
    logic [1:0]  d_mode;
    logic [13:0] d_number;
    logic [15:0] d_led;
    logic [3:0]  d_round;
    logic        d_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reaction_round_ctrl #(
        .NUM_MODES (3),
        .TICKS_0   (1),
        .TICKS_1   (2),
        .TICKS_2   (4),
        .ROUNDS    (2),
        .LED_W     (16),
        .LED_STEP  (30),
        .ERR_CAP   (490)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn_up   (btn_up),
        .i_btn_down (btn_down),
        .i_btn_sel  (btn_sel),
        .i_rand     (rand_v),
        .o_select   (d_select),
        .o_mode     (d_mode),
        .o_number   (d_number),
        .o_led      (d_led),
        .o_round    (d_round),
        .o_done     (d_done)
    );

    // Game model: phase 0..4 = idle, target, count, score, final
    int m_st, m_mode, m_t, m_cnt, m_err, m_total, m_round;
    bit pu, pd, ps, m_valid;

    function automatic int map_t(int r);
        if (r < 1000) return r + 1000;
        if (r > 9999) return r - 7000;
        return r;
    endfunction

    function automatic int ticks(int md);
        return (md == 0) ? 1 : ((md == 1) ? 2 : 4);
    endfunction

    function automatic int bar(int e);
        int k;
        k = e / 30;
        if (k > 16) k = 16;
        return (32'hFFFF >> k) << k;
    endfunction

    function automatic int exp_number();
        case (m_st)
            1: return m_t;
            2: return (m_cnt / ticks(m_mode)) % 10000;
            3: return m_err;
            4: return m_total;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_led();
        case (m_st)
            3: return bar(m_err);
            4: return bar(m_total / 2);
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit up, dn, sl;
        int cur, e;
        if (rst) begin
            m_st = 0; m_mode = 1; m_t = 0; m_cnt = 0; m_err = 0; m_total = 0; m_round = 0;
            pu = 0; pd = 0; ps = 0; m_valid = 1;
        end else begin
            up = btn_up && !pu;
            dn = btn_down && !pd;
            sl = btn_sel && !ps;
            case (m_st)
                0: if (sl) begin
                    m_st = 1; m_round++; m_t = map_t(int'(rand_v));
                end else if (up && !dn) begin
                    m_mode = (m_mode < 2) ? m_mode + 1 : 2;
                end else if (dn && !up) begin
                    m_mode = (m_mode > 0) ? m_mode - 1 : 0;
                end
                1: if (sl) begin m_st = 2; m_cnt = 0; end
                2: if (sl) begin
                    cur = (m_cnt / ticks(m_mode)) % 10000;
                    e = (cur > m_t) ? cur - m_t : m_t - cur;
                    m_err = (e > 490) ? 490 : e;
                    m_total = (m_total + m_err > 9999) ? 9999 : m_total + m_err;
                    m_st = 3;
                end else begin
                    m_cnt++;
                end
                3: if (sl) begin
                    if (m_round == 2) begin
                        m_st = 4;
                    end else begin
                        m_st = 1; m_round++; m_t = map_t(int'(rand_v));
                    end
                end
                4: if (sl) begin m_st = 0; m_round = 0; m_total = 0; end
                default: m_st = 0;
            endcase
            pu = btn_up; pd = btn_down; ps = btn_sel;
        end
    end

    always @(negedge clk) begin
        int en, el;
        if (m_valid) begin
            en = exp_number();
            el = exp_led();
            n_cmp++;
            if (d_select !== 3'(m_st) || d_mode !== 2'(m_mode) || d_number !== 14'(en) ||
                d_led !== 16'(el) || d_round !== 4'(m_round) || d_done !== (m_st == 4)) begin
                n_bad++;
                $display("FAIL model_cycle @%0t: dut sel=%0d mode=%0d num=%0d led=%h rnd=%0d done=%0b required sel=%0d mode=%0d num=%0d led=%h rnd=%0d done=%0b",
                         $time, d_select, d_mode, d_number, d_led, d_round, d_done,
                         m_st, m_mode, en, 16'(el), m_round, (m_st == 4));
            end
        end
    end

    task automatic lit(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Called at a negedge; returns at a negedge two cycles later.
    task automatic press(input bit u, input bit d, input bit s);
        btn_up = u; btn_down = d; btn_sel = s;
        @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lit("reset_select", int'(d_select), 0);
        lit("reset_mode", int'(d_mode), 1);
        lit("reset_number", int'(d_number), 0);
        lit("reset_led", int'(d_led), 0);
        lit("reset_round", int'(d_round), 0);
        lit("reset_done", int'(d_done), 0);

        repeat (3) press(1, 0, 0);
        lit("mode_up_sat", int'(d_mode), 2);
        repeat (5) press(0, 1, 0);
        lit("mode_down_sat", int'(d_mode), 0);
        press(1, 0, 0);
        press(1, 1, 0);
        lit("mode_up_down_same", int'(d_mode), 1);
        press(0, 1, 0);
        btn_up = 1'b1;
        repeat (5) @(negedge clk);
        btn_up = 1'b0;
        @(negedge clk);
        lit("mode_held_once", int'(d_mode), 1);
        press(1, 0, 0);

        // Game A: mode 2, sel wins over simultaneous up
        rand_v = 14'd500;
        press(1, 0, 1);
        lit("sel_priority_mode", int'(d_mode), 2);
        lit("target_low", int'(d_number), 1500);
        lit("target_round1", int'(d_round), 1);
        press(0, 0, 1);
        repeat (39) @(negedge clk);
        lit("count_mode2_40cyc", int'(d_number), 10);
        press(0, 0, 1);
        lit("score_capped", int'(d_number), 490);
        rand_v = 14'd12000;
        press(0, 0, 1);
        lit("target_high", int'(d_number), 5000);
        lit("target_round2", int'(d_round), 2);
        press(0, 0, 1);
        press(0, 0, 1);
        press(0, 0, 1);
        lit("final_a_total", int'(d_number), 980);
        press(0, 0, 1);

        // Game B: errors 60 and 120 in mode 0
        repeat (2) press(0, 1, 0);
        lit("mode_zero", int'(d_mode), 0);
        rand_v = 14'd500;
        press(0, 0, 1);
        press(0, 0, 1);
        repeat (1559) @(negedge clk);
        lit("count_1560", int'(d_number), 1560);
        press(0, 0, 1);
        lit("score_60", int'(d_number), 60);
        lit("led_60", int'(d_led), 16'hFFFC);
        rand_v = 14'd4321;
        press(0, 0, 1);
        lit("target_mid", int'(d_number), 4321);
        press(0, 0, 1);
        repeat (4440) @(negedge clk);
        press(0, 0, 1);
        lit("score_120", int'(d_number), 120);
        lit("led_120", int'(d_led), 16'hFFF0);
        press(0, 0, 1);
        lit("final_select", int'(d_select), 4);
        lit("final_done", int'(d_done), 1);
        lit("final_total", int'(d_number), 180);
        lit("final_led_mean90", int'(d_led), 16'hFFF8);
        press(0, 0, 1);
        lit("idle_round_clear", int'(d_round), 0);
        lit("idle_done_clear", int'(d_done), 0);

        // Game C: large error and count wrap
        rand_v = 14'd500;
        press(0, 0, 1);
        press(0, 0, 1);
        repeat (2999) @(negedge clk);
        press(0, 0, 1);
        lit("score_3000", int'(d_number), 490);
        lit("led_cap", int'(d_led), 0);
        rand_v = 14'd1234;
        press(0, 0, 1);
        press(0, 0, 1);
        repeat (9998) @(negedge clk);
        lit("count_9999", int'(d_number), 9999);
        @(negedge clk);
        lit("count_wrap", int'(d_number), 0);
        repeat (4) @(negedge clk);
        press(0, 0, 1);
        press(0, 0, 1);
        lit("final_c_total", int'(d_number), 980);
        press(0, 0, 1);

        // Reset in the middle of COUNT
        rand_v = 14'd4000;
        press(0, 0, 1);
        press(0, 0, 1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        lit("midrst_select", int'(d_select), 0);
        lit("midrst_number", int'(d_number), 0);
        lit("midrst_round", int'(d_round), 0);
        lit("midrst_mode", int'(d_mode), 1);
        lit("midrst_led", int'(d_led), 0);
        rst = 1'b0;
        @(negedge clk);
        press(0, 0, 1);
        lit("after_rst_target", int'(d_number), 4000);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
